alu_exec_stage: RTL

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// EX-stage ALU with a registered EX/MEM result slot and valid/ready handshakes on both sides.
// Shifts with a nonzero amount are executed one bit per cycle through a shift register.
// Single-cycle ops and zero-amount shifts complete in one cycle.
module alu_exec_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  operation,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  logic [4:0]  dest,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic        ovf,
   output logic [4:0]  out_dest
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [4:0] OP_LUI  = 5'h01;
   localparam logic [4:0] OP_OR   = 5'h02;
   localparam logic [4:0] OP_ADD  = 5'h03;
   localparam logic [4:0] OP_AND  = 5'h04;
   localparam logic [4:0] OP_SUB  = 5'h05;
   localparam logic [4:0] OP_SLL  = 5'h06;
   localparam logic [4:0] OP_SRL  = 5'h07;
   localparam logic [4:0] OP_SLT  = 5'h08;
   localparam logic [4:0] OP_SLTU = 5'h09;
   localparam logic [4:0] OP_NOR  = 5'h0A;
   localparam logic [4:0] OP_JR   = 5'h0B;

   logic [1:0]  state;
   logic [31:0] shift_reg;
   logic [4:0]  count;
   logic        shift_left;
   logic [4:0]  shift_dest;

   logic        issue;
   logic        defer_shift;
   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] alu_res;
   logic        alu_ovf;
   logic [31:0] shift_next;

   // Accept in IDLE, or in HOLD when the current entry retires this same cycle.
   always_comb begin
      in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
      issue    = in_valid && in_ready;
   end

   // Single-cycle ALU result and signed overflow for the operands currently presented.
   always_comb begin
      sum     = a + b;
      diff    = a - b;
      alu_res = 32'd0;
      alu_ovf = 1'b0;
      case (operation)
         OP_LUI:  alu_res = {b[15:0], 16'd0};
         OP_OR:   alu_res = a | b;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         OP_AND:  alu_res = a & b;
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         OP_SLL:  alu_res = b << shamt;
         OP_SRL:  alu_res = b >> shamt;
         OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: alu_res = (a < b) ? 32'd1 : 32'd0;
         OP_NOR:  alu_res = ~(a | b);
         OP_JR:   alu_res = a;
         default: alu_res = 32'd0;
      endcase
      // Zero-amount shifts take the single-cycle path above.
      defer_shift = ((operation == OP_SLL) || (operation == OP_SRL)) && (shamt != 5'd0);
   end

   // One-bit step of the serial shifter in the latched direction.
   always_comb begin
      shift_next = shift_left ? {shift_reg[30:0], 1'b0} : {1'b0, shift_reg[31:1]};
   end

   // Control FSM plus the EX/MEM result register; reset wins over everything, aborting shifts.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         result     <= 32'd0;
         zero       <= 1'b1;
         ovf        <= 1'b0;
         out_dest   <= 5'd0;
         count      <= 5'd0;
         shift_reg  <= 32'd0;
         shift_left <= 1'b0;
         shift_dest <= 5'd0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (issue) begin
                  if (defer_shift) begin
                     shift_reg  <= b;
                     count      <= shamt;
                     shift_left <= (operation == OP_SLL);
                     shift_dest <= dest;
                     out_valid  <= 1'b0;
                     state      <= SHIFT;
                  end else begin
                     result    <= alu_res;
                     zero      <= (alu_res == 32'd0);
                     ovf       <= alu_ovf;
                     out_dest  <= dest;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end else if ((state == HOLD) && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            SHIFT: begin
               shift_reg <= shift_next;
               count     <= count - 5'd1;
               if (count == 5'd1) begin
                  result    <= shift_next;
                  zero      <= (shift_next == 32'd0);
                  ovf       <= 1'b0;
                  out_dest  <= shift_dest;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
